// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the register-use record for the
// ID/EX operand feeder.
package mips_pkg;

    localparam int REG_W = 5;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    // Which register fields an instruction reads/writes
    typedef struct packed {
        logic             uses_rs;
        logic             uses_rt;
        logic [REG_W-1:0] dest;
        logic             is_load;
    } reg_use_t;

    // Immediate-shamt shifts take their operand from rt only
    function automatic logic is_shift_imm(input logic [5:0] funct);
        return (funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA);
    endfunction

    // True when a nonzero register idx is read by an instruction
    function automatic logic src_hit(input reg_use_t u,
                                     input logic [REG_W-1:0] rs,
                                     input logic [REG_W-1:0] rt,
                                     input logic [REG_W-1:0] idx);
        return (idx != '0) && ((u.uses_rs && (rs == idx)) ||
                               (u.uses_rt && (rt == idx)));
    endfunction

endpackage

// File: rtl/mips_reg_use_decode.sv
// Combinational decode of a raw MIPS instruction into its register usage.
module mips_reg_use_decode
    import mips_pkg::*;
(
    input  logic [31:0] instr,
    output reg_use_t    reg_use
);

    logic [5:0] op;
    logic [5:0] funct;
    logic       unused_imm;

    assign op         = instr[31:26];
    assign funct      = instr[5:0];
    assign unused_imm = ^instr[10:6];

    // rs is read by everything except the shamt shifts; dest follows format
    always_comb begin
        reg_use         = '0;
        reg_use.uses_rs = 1'b1;
        reg_use.is_load = (op == OP_LW);
        case (op)
            OP_RTYPE: begin
                reg_use.uses_rs = !is_shift_imm(funct);
                reg_use.uses_rt = 1'b1;
                reg_use.dest    = instr[15:11];
            end
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI,
            OP_SLTI, OP_SLTIU, OP_LW: begin
                reg_use.dest = instr[20:16];
            end
            OP_BEQ, OP_BNE, OP_SW: begin
                reg_use.uses_rt = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_ex_operand_feeder.sv
// ID/EX operand feeder: latches ID instructions into EX, resolves
// load-use hazards with a one-cycle bubble, and drives forwarded
// ALU operands. MIPS_FWD_EN enables EX/MEM and MEM/WB output
// forwarding; without it, any pending producer in EX or EX/MEM stalls
// ID and MEM/WB is covered only by write-through at capture.
module mips_ex_operand_feeder
    import mips_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RADDR = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [XLEN-1:0]  id_instr,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs_data,
    input  logic [XLEN-1:0]  id_rt_data,
    input  logic             exmem_wr_en,
    input  logic [RADDR-1:0] exmem_rd,
    input  logic [XLEN-1:0]  exmem_data,
    input  logic             exmem_is_load,
    input  logic             memwb_wr_en,
    input  logic [RADDR-1:0] memwb_rd,
    input  logic [XLEN-1:0]  memwb_data,
    input  logic             flush,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_instr,
    output logic [XLEN-1:0]  ex_reg_a,
    output logic [XLEN-1:0]  ex_reg_b,
    output logic [XLEN-1:0]  ex_pc,
    output logic [RADDR-1:0] ex_dest,
    output logic             ex_is_load
);

    logic             ex_valid_q;
    logic [XLEN-1:0]  ex_instr_q, ex_a_q, ex_b_q, ex_pc_q;
    reg_use_t         id_use, ex_use;
    logic [RADDR-1:0] id_rs, id_rt;
    logic             hazard;
    logic [XLEN-1:0]  wt_a, wt_b;

    assign id_rs = id_instr[25:21];
    assign id_rt = id_instr[20:16];

    mips_reg_use_decode u_id_dec (.instr(id_instr[31:0]),   .reg_use(id_use));
    mips_reg_use_decode u_ex_dec (.instr(ex_instr_q[31:0]), .reg_use(ex_use));

    assign ex_valid   = ex_valid_q;
    assign ex_instr   = ex_instr_q;
    assign ex_pc      = ex_pc_q;
    assign ex_dest    = ex_valid_q ? ex_use.dest : '0;
    assign ex_is_load = ex_valid_q & ex_use.is_load;

`ifdef MIPS_FWD_EN
    // Only a load in EX can't be forwarded in time
    assign hazard = ex_is_load & src_hit(id_use, id_rs, id_rt, ex_dest);
`else
    // No forwarding: wait out any in-flight producer in EX or EX/MEM
    assign hazard = (ex_valid_q & src_hit(id_use, id_rs, id_rt, ex_dest)) |
                    (exmem_wr_en & src_hit(id_use, id_rs, id_rt, exmem_rd));
`endif

    // Flush drains ID regardless of any hazard
    assign id_ready = flush | ~hazard;

    // Register file write in the same cycle as the read: take the new value
    assign wt_a = (memwb_wr_en && memwb_rd != '0 && memwb_rd == id_rs) ? memwb_data : id_rs_data;
    assign wt_b = (memwb_wr_en && memwb_rd != '0 && memwb_rd == id_rt) ? memwb_data : id_rt_data;

    // EX register: capture from ID, or load a bubble on flush/stall/idle
    always_ff @(posedge clk) begin
        if (reset || flush || !id_valid || hazard) begin
            ex_valid_q <= 1'b0;
            ex_instr_q <= '0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_pc_q    <= '0;
        end else begin
            ex_valid_q <= 1'b1;
            ex_instr_q <= id_instr;
            ex_a_q     <= wt_a;
            ex_b_q     <= wt_b;
            ex_pc_q    <= id_pc;
        end
    end

`ifdef MIPS_FWD_EN
    logic [RADDR-1:0] ex_rs, ex_rt;
    assign ex_rs = ex_instr_q[25:21];
    assign ex_rt = ex_instr_q[20:16];

    // Operand A: EX/MEM (non-load) beats MEM/WB beats latched; $0 never forwarded
    always_comb begin
        ex_reg_a = ex_a_q;
        if (ex_use.uses_rs && ex_rs != '0) begin
            if (exmem_wr_en && !exmem_is_load && exmem_rd == ex_rs)
                ex_reg_a = exmem_data;
            else if (memwb_wr_en && memwb_rd == ex_rs)
                ex_reg_a = memwb_data;
        end
    end

    // Operand B: same priority on rt
    always_comb begin
        ex_reg_b = ex_b_q;
        if (ex_use.uses_rt && ex_rt != '0) begin
            if (exmem_wr_en && !exmem_is_load && exmem_rd == ex_rt)
                ex_reg_b = exmem_data;
            else if (memwb_wr_en && memwb_rd == ex_rt)
                ex_reg_b = memwb_data;
        end
    end
`else
    logic unused_nofwd;
    assign unused_nofwd = ^{exmem_data, exmem_is_load, ex_use.uses_rs, ex_use.uses_rt};

    assign ex_reg_a = ex_a_q;
    assign ex_reg_b = ex_b_q;
`endif

endmodule

// File: tb/tb_mips_ex_operand_feeder.sv
// Directed bench for mips_ex_operand_feeder; expectations follow the
// build (MIPS_FWD_EN defined or not).
module tb_mips_ex_operand_feeder;

    localparam logic [31:0] ADD3   = 32'h0022_1820; // add  $3,$1,$2
    localparam logic [31:0] ADDU7  = 32'h00A6_3821; // addu $7,$5,$6
    localparam logic [31:0] ADDU0  = 32'h0006_3821; // addu $7,$0,$6
    localparam logic [31:0] LW4    = 32'h8D24_0000; // lw   $4,0($9)
    localparam logic [31:0] LW1    = 32'h8D21_0000; // lw   $1,0($9)
    localparam logic [31:0] SUB6   = 32'h0082_3022; // sub  $6,$4,$2
    localparam logic [31:0] ADD8   = 32'h00C2_4020; // add  $8,$6,$2
    localparam logic [31:0] SLLV3  = 32'h0022_1804; // sllv $3,$2,$1
    localparam logic [31:0] SLL3   = 32'h0022_1880; // sll  $3,$2,2 (rs field = $1)

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_ready;
    logic [31:0] id_instr, id_pc, id_rs_data, id_rt_data;
    logic        exmem_wr_en, exmem_is_load, memwb_wr_en, flush;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_data, memwb_data;
    logic        ex_valid, ex_is_load;
    logic [31:0] ex_instr, ex_reg_a, ex_reg_b, ex_pc;
    logic [4:0]  ex_dest;

    int n_chk = 0;
    int n_err = 0;

    mips_ex_operand_feeder dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .exmem_wr_en(exmem_wr_en), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
        .exmem_is_load(exmem_is_load),
        .memwb_wr_en(memwb_wr_en), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .flush(flush),
        .ex_valid(ex_valid), .ex_instr(ex_instr), .ex_reg_a(ex_reg_a), .ex_reg_b(ex_reg_b),
        .ex_pc(ex_pc), .ex_dest(ex_dest), .ex_is_load(ex_is_load)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] ins, input logic [31:0] pc,
                           input logic [31:0] a, input logic [31:0] b);
        id_valid = 1'b1; id_instr = ins; id_pc = pc; id_rs_data = a; id_rt_data = b;
    endtask

    task automatic idle();
        id_valid = 1'b0; id_instr = '0; id_pc = '0; id_rs_data = '0; id_rt_data = '0;
    endtask

    task automatic clr_fwd();
        exmem_wr_en = 1'b0; exmem_rd = '0; exmem_data = '0; exmem_is_load = 1'b0;
        memwb_wr_en = 1'b0; memwb_rd = '0; memwb_data = '0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0;
        idle(); clr_fwd();
        tick(); tick();
        chk("rst_valid", ex_valid, 0);
        chk("rst_instr", ex_instr, 0);
        chk("rst_a", ex_reg_a, 0);
        chk("rst_b", ex_reg_b, 0);
        chk("rst_pc", ex_pc, 0);
        chk("rst_dest", ex_dest, 0);
        chk("rst_load", ex_is_load, 0);
        chk("rst_ready", id_ready, 1);
        reset = 1'b0;

        // basic capture, one-cycle latency
        present(ADD3, 32'h100, 32'd3, 32'd2); #1;
        chk("add_ready", id_ready, 1);
        tick(); idle(); #1;
        chk("add_valid", ex_valid, 1);
        chk("add_instr", ex_instr, ADD3);
        chk("add_a", ex_reg_a, 3);
        chk("add_b", ex_reg_b, 2);
        chk("add_dest", ex_dest, 3);
        chk("add_pc", ex_pc, 32'h100);

        // forwarding priority on addu $7,$5,$6
        present(ADDU7, 32'h104, 32'h55, 32'h66);
        tick(); idle();
        exmem_wr_en = 1; exmem_rd = 5; exmem_data = 32'h1234;
        memwb_wr_en = 1; memwb_rd = 5; memwb_data = 32'h9; #1;
`ifdef MIPS_FWD_EN
        chk("fwd_exmem_a", ex_reg_a, 32'h1234);
`else
        chk("fwd_exmem_a", ex_reg_a, 32'h55);
`endif
        chk("fwd_exmem_b", ex_reg_b, 32'h66);
        exmem_is_load = 1; #1;
`ifdef MIPS_FWD_EN
        chk("fwd_ld_skip_a", ex_reg_a, 32'h9);
`else
        chk("fwd_ld_skip_a", ex_reg_a, 32'h55);
`endif
        exmem_wr_en = 0; exmem_is_load = 0; #1;
`ifdef MIPS_FWD_EN
        chk("fwd_memwb_a", ex_reg_a, 32'h9);
`else
        chk("fwd_memwb_a", ex_reg_a, 32'h55);
`endif
        clr_fwd();

        // load-use stall
        present(LW4, 32'h108, 32'h9000, 32'h0);
        tick();
        chk("lw_is_load", ex_is_load, 1);
        chk("lw_dest", ex_dest, 4);
        present(SUB6, 32'h10c, 32'h1111, 32'h22); #1;
        chk("lu_ready", id_ready, 0);
        tick();
        chk("lu_bubble_v", ex_valid, 0);
        chk("lu_bubble_i", ex_instr, 0);
        exmem_wr_en = 1; exmem_rd = 4; exmem_is_load = 1; exmem_data = 32'hDEAD; #1;
`ifdef MIPS_FWD_EN
        chk("lu_ready2", id_ready, 1);
        tick(); clr_fwd();
        memwb_wr_en = 1; memwb_rd = 4; memwb_data = 32'hABCD; #1;
`else
        chk("lu_ready2", id_ready, 0);
        tick(); clr_fwd();
        memwb_wr_en = 1; memwb_rd = 4; memwb_data = 32'hABCD; #1;
        chk("lu_ready3", id_ready, 1);
        tick();
`endif
        idle();
        chk("lu_valid", ex_valid, 1);
        chk("lu_instr", ex_instr, SUB6);
        chk("lu_a", ex_reg_a, 32'hABCD);
        chk("lu_b", ex_reg_b, 32'h22);
        chk("lu_pc", ex_pc, 32'h10c);
        clr_fwd();

        // non-load producer in EX: stalls only without forwarding
        present(ADD8, 32'h110, 32'h0, 32'h0); #1;
`ifdef MIPS_FWD_EN
        chk("alu_dep_ready", id_ready, 1);
`else
        chk("alu_dep_ready", id_ready, 0);
`endif
        idle();

        // flush overrides a load-use stall
        present(LW1, 32'h114, 32'h9000, 32'h0);
        tick();
        present(SLLV3, 32'h118, 32'h1, 32'h2); #1;
        chk("fl_stall_ready", id_ready, 0);
        flush = 1; #1;
        chk("fl_ready", id_ready, 1);
        tick(); flush = 0; idle(); #1;
        chk("fl_valid", ex_valid, 0);
        chk("fl_instr", ex_instr, 0);

        // immediate shift does not read rs
        present(LW1, 32'h11c, 32'h9000, 32'h0);
        tick();
        present(SLL3, 32'h120, 32'h31, 32'h2); #1;
        chk("sll_ready", id_ready, 1);
        tick(); idle();
        exmem_wr_en = 1; exmem_rd = 1; exmem_data = 32'h999; #1;
        chk("sll_a_unfwd", ex_reg_a, 32'h31);
        chk("sll_dest", ex_dest, 3);
        clr_fwd();

        // $0 is never forwarded
        present(ADDU0, 32'h124, 32'h0, 32'h66);
        tick(); idle();
        exmem_wr_en = 1; exmem_rd = 0; exmem_data = 32'hFFFF;
        memwb_wr_en = 1; memwb_rd = 0; memwb_data = 32'hEEEE; #1;
        chk("zero_a", ex_reg_a, 0);
        chk("zero_b", ex_reg_b, 32'h66);
        chk("zero_dest", ex_dest, 7);
        clr_fwd();

        // write-through at capture
        present(ADDU7, 32'h128, 32'h55, 32'h66);
        memwb_wr_en = 1; memwb_rd = 5; memwb_data = 32'h77;
        tick(); idle(); clr_fwd(); #1;
        chk("wt_a", ex_reg_a, 32'h77);
        chk("wt_b", ex_reg_b, 32'h66);

        // reset during a stall
        present(LW1, 32'h12c, 32'h9000, 32'h0);
        tick();
        present(SLLV3, 32'h130, 32'h1, 32'h2); #1;
        chk("rs_stall_ready", id_ready, 0);
        reset = 1;
        tick();
        chk("rs_valid", ex_valid, 0);
        chk("rs_load", ex_is_load, 0);
        chk("rs_ready", id_ready, 1);
        reset = 0; idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
